if_fetch_queue: RTL and testbench



---
 rtl/if_pkg.sv | 19 +
 rtl/if_queue_mem.sv | 31 +++
 rtl/if_fetch_queue.sv | 139 +++++++++++++
 tb/tb_if_fetch_queue.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch queue.
//   IF_NOP_INSTR : filler instruction shown when the queue head is empty
//                  (AND r0,r0,r0, cond AL)
//   IF_PC_W      : default pc field width
//   IF_INSTR_W   : default instruction field width
//   if_entry_t   : one queued {pc, instruction} pair at the default widths
package if_pkg;

  localparam int IF_PC_W    = 32;
  localparam int IF_INSTR_W = 32;

  localparam logic [IF_INSTR_W-1:0] IF_NOP_INSTR = 32'hE000_0000;

  typedef struct packed {
    logic [IF_PC_W-1:0]    pc;
    logic [IF_INSTR_W-1:0] instruction;
  } if_entry_t;

endpackage

// File: rtl/if_queue_mem.sv
// Storage array for the fetch queue: DEPTH words of WIDTH bits.
// Ports:
//   clk   in  clock
//   we    in  write enable (synchronous write at posedge clk)
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address (asynchronous read)
//   rdata out word stored at raddr
// The array carries no reset; which words are meaningful is tracked by the
// occupancy counter in the parent.
module if_queue_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// DEPTH-entry FIFO of {pc, instruction} pairs between fetch and decode.
// Replaces the single IF/ID register so fetch keeps running while decode
// is frozen; flush discards everything, an empty head presents a NOP.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     fetch-side handshake (in_ready = not full)
//   pc_in, instruction_in fetched pc+4 and instruction
//   flush                 branch taken: drop all entries and the input
//   freeze                decode stalled: head holds
//   out_valid             head entry is real
//   pc, instruction       head entry, or 0 / NOP_INSTR when empty
//   count                 occupancy 0..DEPTH
// Optional (macro IF_QUEUE_STATS_EN):
//   full_stall_cycles     cycles fetch was blocked by a full queue (sat.)
//   flushed_entries       entries discarded by flushes (sat.)
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int                 PC_W      = IF_PC_W,
  parameter int                 INSTR_W   = IF_INSTR_W,
  parameter int                 DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_NOP_INSTR)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          pc_in,
  input  logic [INSTR_W-1:0]       instruction_in,
  input  logic                     flush,
  input  logic                     freeze,
  output logic                     out_valid,
  output logic [PC_W-1:0]          pc,
  output logic [INSTR_W-1:0]       instruction,
  output logic [$clog2(DEPTH):0]   count
`ifdef IF_QUEUE_STATS_EN
  ,
  output logic [15:0]              full_stall_cycles,
  output logic [15:0]              flushed_entries
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = PC_W + INSTR_W;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  // Ready and valid come from registered occupancy only, so neither flush
  // nor freeze has a combinational path to in_ready.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & ~freeze & ~flush;

  if_queue_mem #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({pc_in, instruction_in}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign pc          = out_valid ? head[ENT_W-1:INSTR_W] : '0;
  assign instruction = out_valid ? head[INSTR_W-1:0]     : NOP_INSTR;

  // Pointer widths match log2(DEPTH), so increments wrap modulo DEPTH.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

`ifdef IF_QUEUE_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] flushed_q, flushed_d;

  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [16:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + b;
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_comb begin
    stall_d   = stall_q;
    flushed_d = flushed_q;
    if (in_valid && !in_ready) stall_d = sat_add16(stall_q, 17'd1);
    // The entry offered in the flush cycle counts as discarded too.
    if (flush) flushed_d = sat_add16(flushed_q, 17'(count_q) + 17'(in_valid));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      flushed_q <= '0;
    end else begin
      stall_q   <= stall_d;
      flushed_q <= flushed_d;
    end
  end

  assign full_stall_cycles = stall_q;
  assign flushed_entries   = flushed_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  import if_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, freeze;
  logic        in_ready, out_valid;
  logic [31:0] pc_in, instruction_in, pc, instruction;
  logic [2:0]  count;
`ifdef IF_QUEUE_STATS_EN
  logic [15:0] full_stall_cycles, flushed_entries;
  int          m_stall = 0, m_flushed = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ordered list of entries that should be in the queue.
  if_entry_t exp_q[$];
  bit        model_full = 1'b0;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pc_in          (pc_in),
    .instruction_in (instruction_in),
    .flush          (flush),
    .freeze         (freeze),
    .out_valid      (out_valid),
    .pc             (pc),
    .instruction    (instruction),
    .count          (count)
`ifdef IF_QUEUE_STATS_EN
    ,
    .full_stall_cycles (full_stall_cycles),
    .flushed_entries   (flushed_entries)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model update at the clock edge: accept pushes into the expected list.
  always @(posedge clk) begin
`ifdef IF_QUEUE_STATS_EN
    if (rst) begin
      m_stall = 0; m_flushed = 0;
    end else begin
      if (in_valid && model_full) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
      if (flush) begin
        m_flushed = m_flushed + exp_q.size() + (in_valid ? 1 : 0);
        if (m_flushed > 65535) m_flushed = 65535;
      end
    end
`endif
    if (rst || flush) exp_q.delete();
    else if (in_valid && !model_full) exp_q.push_back('{pc: pc_in, instruction: instruction_in});
  end

  // Monitor: compare outputs mid-cycle, consume the head when decode takes it.
  always @(negedge clk) begin
    int sz;
    sz = exp_q.size();
    model_full = (sz == DEPTH);
    chk("count", 64'(count), 64'(sz));
    chk("in_ready", 64'(in_ready), 64'(sz != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sz != 0));
    if (sz != 0) begin
      chk("head_pc", 64'(pc), 64'(exp_q[0].pc));
      chk("head_instr", 64'(instruction), 64'(exp_q[0].instruction));
      if (!rst && !flush && !freeze) void'(exp_q.pop_front());
    end else begin
      chk("nop_pc", 64'(pc), 64'd0);
      chk("nop_instr", 64'(instruction), 64'hE000_0000);
    end
`ifdef IF_QUEUE_STATS_EN
    chk("full_stall_cycles", 64'(full_stall_cycles), 64'(m_stall));
    chk("flushed_entries", 64'(flushed_entries), 64'(m_flushed));
`endif
  end

  task automatic step(input logic v, input logic [31:0] p, input logic [31:0] ins,
                      input logic frz, input logic fl);
    in_valid = v; pc_in = p; instruction_in = ins; freeze = frz; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc_in = '0; instruction_in = '0;
    flush = 1'b0; freeze = 1'b0;
    do_reset();
    idle(2);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_instr", 64'(instruction), 64'hE000_0000);

    // Fill under freeze; fifth push must be refused, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * (i + 1)), 32'(32'hA1 + i), 1'b1, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h14, 32'hA5, 1'b1, 1'b0);
    chk("fifth_ignored_head", 64'(pc), 64'h4);
    idle(6);

    // Streaming push+pop across pointer wrap; occupancy stays at one.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1'b1, 32'(4 * (i + 1)), 32'(32'hB0 + i), 1'b0, 1'b0);
      chk("stream_count", 64'(count), 64'd1);
    end
    idle(3);

    // Flush beats freeze and a same-cycle push.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h20 + 4 * i), 32'(32'hC0 + i), 1'b1, 1'b0);
    step(1'b1, 32'h40, 32'hC4, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_pc", 64'(pc), 64'd0);
    idle(2);

    // Full: a pop does not open the slot in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'(32'h50 + 4 * i), 32'(32'hD0 + i), 1'b1, 1'b0);
    step(1'b1, 32'h60, 32'hD5, 1'b0, 1'b0);
    chk("pop_full_count", 64'(count), 64'd3);
    step(1'b1, 32'h60, 32'hD5, 1'b1, 1'b0);
    chk("next_push_count", 64'(count), 64'd4);
`ifdef IF_QUEUE_STATS_EN
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'(32'h70 + 4 * i), 32'(32'hE0 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h90, 32'hE5, 1'b1, 1'b0);
    chk("stall5", 64'(full_stall_cycles), 64'd5);
    step(1'b1, 32'h90, 32'hE5, 1'b1, 1'b1);
    chk("flushed5", 64'(flushed_entries), 64'd5);
`endif
    idle(6);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 9) < 7, $urandom, $urandom,
           $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end
    rst = 1'b0;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
